// File: rtl/qos_pkg.sv
// -----------------------------------------------------------------------------
// qos_pkg
// Shared definitions for the QoS egress merger: lane count, default word and
// weight widths, the arbiter state encoding and a lane-to-strobe helper.
// -----------------------------------------------------------------------------
package qos_pkg;

  localparam int NUM_LANES        = 4;
  localparam int LANE_W           = 2;
  localparam int QOS_DATA_WIDTH   = 12;
  localparam int QOS_WEIGHT_WIDTH = 4;
  localparam int STAT_W           = 8;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

  // One-hot pop strobe vector for a lane index.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot       = '0;
    lane_onehot[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/qos_merger_buf.sv
// -----------------------------------------------------------------------------
// qos_merger_buf
// Two-entry output FIFO feeding the link transmitter. A push and a pop in the
// same cycle are legal at any occupancy, including full (the slot being read
// out is the one overwritten).
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push_i          write push_data_i at the end of this cycle
//   push_data_i     word to write
//   pop_i           head consumed this cycle (caller guarantees valid_o)
//   data_o          head entry
//   valid_o         buffer holds at least one word
//   occ_o           occupancy, 0..2
// -----------------------------------------------------------------------------
module qos_merger_buf #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset because the head entry drives data_out,
      // which must read zero out of reset; a deeper RAM would not be.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/qos_egress_merger.sv
// -----------------------------------------------------------------------------
// qos_egress_merger
// Drains the four per-class egress FIFOs with weighted round-robin and merges
// them into one valid/ready stream. Pops are credit-limited so the 2-entry
// output buffer never overflows and no word is lost.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   init                   weights sampled while high; no pops
//   weight0..3             burst length per grant, 0 disables the lane
//   fifo_empty[3:0]        per-lane FIFO empty flags
//   fifo_dataout0..3       FIFO read data, valid the cycle after the pop
//   popBP0..3              pop strobes, at most one high per cycle
//   ready_in               downstream accepts data_out
//   valid_out, data_out    output stream head
//   idle_out               nothing buffered, nothing in flight, no work
//   stat_idx, stat_count   (QOS_MERGER_STATS_EN only) per-lane delivered count
//
// Build option: define QOS_MERGER_STATS_EN to add the delivery counters.
// -----------------------------------------------------------------------------
module qos_egress_merger
  import qos_pkg::*;
#(
  parameter int DATA_WIDTH   = QOS_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = QOS_WEIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [WEIGHT_WIDTH-1:0] weight0,
  input  logic [WEIGHT_WIDTH-1:0] weight1,
  input  logic [WEIGHT_WIDTH-1:0] weight2,
  input  logic [WEIGHT_WIDTH-1:0] weight3,
  input  logic [NUM_LANES-1:0]    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout0,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout1,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout2,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout3,
  output logic                    popBP0,
  output logic                    popBP1,
  output logic                    popBP2,
  output logic                    popBP3,
  input  logic                    ready_in,
`ifdef QOS_MERGER_STATS_EN
  input  logic [LANE_W-1:0]       stat_idx,
  output logic [STAT_W-1:0]       stat_count,
`endif
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    idle_out
);

`ifdef QOS_MERGER_STATS_EN
  // Each buffered word carries its source lane so delivery can be attributed.
  localparam int BUF_W = DATA_WIDTH + LANE_W;
`else
  localparam int BUF_W = DATA_WIDTH;
`endif

  logic [WEIGHT_WIDTH-1:0] weight_in [NUM_LANES];
  logic [DATA_WIDTH-1:0]   lane_data [NUM_LANES];

  assign weight_in = '{weight0, weight1, weight2, weight3};
  assign lane_data = '{fifo_dataout0, fifo_dataout1, fifo_dataout2, fifo_dataout3};

  // Arbiter state
  arb_state_e              state_q;
  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_LANES];
  logic [LANE_W-1:0]       ptr_q;
  logic [WEIGHT_WIDTH-1:0] burst_q;
  logic                    inflight_q;
  logic [LANE_W-1:0]       inflight_lane_q;

  // Buffer interface
  logic [BUF_W-1:0] push_word;
  logic [BUF_W-1:0] buf_word;
  logic [1:0]       occ;
  logic             deq;

  // Arbitration
  logic [NUM_LANES-1:0]    lane_ok;
  logic [WEIGHT_WIDTH-1:0] burst_eff;
  logic [LANE_W-1:0]       sel_lane;
  logic                    sel_valid;
  logic                    sel_fresh;
  logic [LANE_W-1:0]       idx;
  logic [2:0]              committed;
  logic                    credit_ok;
  logic                    pop;
  logic [NUM_LANES-1:0]    pop_vec;

  always_comb begin
    lane_ok = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_ok[k] = !fifo_empty[k] && (weight_q[k] != '0);
    end
  end

  // A lane resuming after IDLE or INIT starts a fresh burst.
  assign burst_eff = (state_q == ST_ACTIVE) ? burst_q : '0;

  // Keep the granted lane while its burst lasts; otherwise hand the grant to
  // the next ready lane after the pointer (the pointer itself last), in the
  // same cycle, so a lane switch costs no bubble.
  always_comb begin
    sel_lane  = ptr_q;
    sel_valid = 1'b0;
    sel_fresh = 1'b0;
    idx       = '0;
    if (lane_ok[ptr_q] && (burst_eff < weight_q[ptr_q])) begin
      sel_valid = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_LANES; i++) begin
        idx = ptr_q + LANE_W'(i);
        if (!sel_valid && lane_ok[idx]) begin
          sel_valid = 1'b1;
          sel_fresh = 1'b1;
          sel_lane  = idx;
        end
      end
    end
  end

  // Credit: words already buffered or in flight, less the one leaving now,
  // must leave room for the word this pop will deliver.
  assign deq       = valid_out & ready_in;
  assign committed = 3'(occ) + 3'(inflight_q);
  assign credit_ok = committed < (3'd2 + 3'(deq));
  assign pop       = !reset && !init && sel_valid && credit_ok;
  assign pop_vec   = pop ? lane_onehot(sel_lane) : '0;

  assign popBP0 = pop_vec[0];
  assign popBP1 = pop_vec[1];
  assign popBP2 = pop_vec[2];
  assign popBP3 = pop_vec[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      weight_q        <= '{default: WEIGHT_WIDTH'(1)};
      ptr_q           <= '0;
      burst_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_lane_q <= '0;
    end else begin
      inflight_q      <= pop;
      inflight_lane_q <= sel_lane;
      if (init) begin
        state_q  <= ST_INIT;
        weight_q <= weight_in;
        ptr_q    <= '0;
        burst_q  <= '0;
      end else begin
        state_q <= sel_valid ? ST_ACTIVE : ST_IDLE;
        if (pop) begin
          ptr_q   <= sel_lane;
          burst_q <= sel_fresh ? WEIGHT_WIDTH'(1) : burst_eff + WEIGHT_WIDTH'(1);
        end else begin
          burst_q <= burst_eff;
        end
      end
    end
  end

`ifdef QOS_MERGER_STATS_EN
  assign push_word = {inflight_lane_q, lane_data[inflight_lane_q]};
`else
  assign push_word = lane_data[inflight_lane_q];
`endif

  qos_merger_buf #(
    .WIDTH (BUF_W)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (push_word),
    .pop_i       (deq),
    .data_o      (buf_word),
    .valid_o     (valid_out),
    .occ_o       (occ)
  );

  assign data_out = buf_word[DATA_WIDTH-1:0];
  assign idle_out = (occ == 2'd0) && !inflight_q && !(|lane_ok);

`ifdef QOS_MERGER_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_LANES];
  logic [LANE_W-1:0] head_lane;

  assign head_lane = buf_word[DATA_WIDTH +: LANE_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '{default: '0};
    end else if (init) begin
      stat_q <= '{default: '0};
    end else if (deq && (stat_q[head_lane] != '1)) begin
      stat_q[head_lane] <= stat_q[head_lane] + STAT_W'(1);
    end
  end

  assign stat_count = stat_q[stat_idx];
`endif

endmodule

// File: tb/tb_qos_egress_merger.sv
// -----------------------------------------------------------------------------
// tb_qos_egress_merger
// Emulates the four egress FIFOs, predicts the delivery order from the
// weighted round-robin rules over the loaded contents, and checks the output
// stream through a scoreboard queue drained by an independent monitor.
// -----------------------------------------------------------------------------
module tb_qos_egress_merger;

  localparam int DW = 12;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [WW-1:0] w_drv [4];
  logic [3:0]    fifo_empty = 4'hF;
  logic [DW-1:0] fifo_dout [4] = '{default: '0};
  wire  [3:0]    pop_bp;
  logic          ready_in;
  wire           valid_out;
  wire  [DW-1:0] data_out;
  wire           idle_out;
`ifdef QOS_MERGER_STATS_EN
  logic [1:0]    stat_idx = 2'd0;
  wire  [7:0]    stat_count;
`endif

  qos_egress_merger dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .weight0       (w_drv[0]),
    .weight1       (w_drv[1]),
    .weight2       (w_drv[2]),
    .weight3       (w_drv[3]),
    .fifo_empty    (fifo_empty),
    .fifo_dataout0 (fifo_dout[0]),
    .fifo_dataout1 (fifo_dout[1]),
    .fifo_dataout2 (fifo_dout[2]),
    .fifo_dataout3 (fifo_dout[3]),
    .popBP0        (pop_bp[0]),
    .popBP1        (pop_bp[1]),
    .popBP2        (pop_bp[2]),
    .popBP3        (pop_bp[3]),
    .ready_in      (ready_in),
`ifdef QOS_MERGER_STATS_EN
    .stat_idx      (stat_idx),
    .stat_count    (stat_count),
`endif
    .valid_out     (valid_out),
    .data_out      (data_out),
    .idle_out      (idle_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- egress FIFO emulation ----------------
  logic [DW-1:0] fq [4][$];
  int            pop_cnt [4] = '{default: 0};
  int            pop_cyc [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) fq[k].delete();
      fifo_empty <= 4'hF;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop_bp[k] && fq[k].size() > 0) begin
          fifo_dout[k] <= fq[k].pop_front();
          pop_cnt[k]++;
          pop_cyc.push_back(cyc);
        end
        fifo_empty[k] <= (fq[k].size() == 0);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] exp_q [$];
  int            del_cyc [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      check("pop_onehot", 32'($onehot0(pop_bp)), 1);
      check("pop_nonempty", 32'(|(pop_bp & fifo_empty)), 0);
      if (prev_stall) begin
        check("hold_valid", 32'(valid_out), 1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      if (valid_out && ready_in) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
        del_cyc.push_back(cyc);
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mq [4][$];
  int            wm [4];
  bit            rand_ready = 1'b0;

  // Weighted round-robin over the loaded words: keep the granted lane while
  // it has words and burst budget, else the next nonempty enabled lane.
  task automatic build_expected();
    int ptr   = 0;
    int burst = 0;
    bit found;
    forever begin
      found = 1'b0;
      if (mq[ptr].size() > 0 && wm[ptr] > 0 && burst < wm[ptr]) begin
        found = 1'b1;
      end else begin
        for (int i = 1; i <= 4; i++) begin
          int l = (ptr + i) % 4;
          if (!found && mq[l].size() > 0 && wm[l] > 0) begin
            ptr   = l;
            burst = 0;
            found = 1'b1;
          end
        end
      end
      if (!found) break;
      exp_q.push_back(mq[ptr].pop_front());
      burst++;
    end
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test(input int a, input int b, input int c, input int d);
    init = 1'b1;
    wm   = '{a, b, c, d};
    for (int k = 0; k < 4; k++) w_drv[k] = WW'(wm[k]);
    tick(2);
    for (int k = 0; k < 4; k++) begin
      fq[k].delete();
      mq[k].delete();
      pop_cnt[k] = 0;
    end
    pop_cyc.delete();
    del_cyc.delete();
  endtask

  task automatic load(input int lane, input logic [DW-1:0] val);
    fq[lane].push_back(val);
    mq[lane].push_back(val);
  endtask

  task automatic release_init();
    build_expected();
    tick(1);
    init = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (rand_ready) ready_in = ($urandom_range(3) != 0);
      if (exp_q.size() == 0 && idle_out) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 1);
    ready_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] first_word;
    int            npops;

    reset    = 1'b1;
    init     = 1'b0;
    ready_in = 1'b0;
    for (int k = 0; k < 4; k++) w_drv[k] = WW'(1);
    tick(3);
    check("rst_pop", 32'(pop_bp), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_idle", 32'(idle_out), 1);
    reset = 1'b0;
    tick(2);
    check("post_rst_idle", 32'(idle_out), 1);

    // Three words on lane 0, back-to-back pops, 2-cycle latency
    start_test(1, 1, 1, 1);
    load(0, 12'h101);
    load(0, 12'h102);
    load(0, 12'h103);
    ready_in = 1'b1;
    release_init();
    drain("t1_drain", 50);
    check("t1_pops", 32'(pop_cyc.size()), 3);
    check("t1_dels", 32'(del_cyc.size()), 3);
    if (pop_cyc.size() == 3 && del_cyc.size() == 3) begin
      check("t1_pop_span", 32'(pop_cyc[2] - pop_cyc[0]), 2);
      check("t1_latency", 32'(del_cyc[0] - pop_cyc[0]), 2);
      check("t1_del_span", 32'(del_cyc[2] - del_cyc[0]), 2);
    end
    check("t1_idle", 32'(idle_out), 1);

    // Weights 2,1,1,1 with 4 words per lane: order from the scoreboard,
    // and 16 deliveries on consecutive cycles
    start_test(2, 1, 1, 1);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) load(k, DW'(12'h200 + k * 16 + i));
    ready_in = 1'b1;
    release_init();
    drain("t2_drain", 100);
    check("t2_dels", 32'(del_cyc.size()), 16);
    if (del_cyc.size() == 16) check("t2_no_bubble", 32'(del_cyc[15] - del_cyc[0]), 15);

    // Backpressure from the start: only two pops, head word held
    start_test(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) load(2, DW'(12'h3A0 + i));
    first_word = 12'h3A0;
    ready_in   = 1'b0;
    release_init();
    tick(10);
    check("t3_pops", 32'(pop_cnt[2]), 2);
    check("t3_valid", 32'(valid_out), 1);
    check("t3_head", 32'(data_out), 32'(first_word));
    ready_in = 1'b1;
    drain("t3_drain", 50);
    check("t3_dels", 32'(del_cyc.size()), 4);

    // Lane 1 disabled while holding data
    start_test(1, 0, 1, 1);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 3; i++) load(k, DW'(12'h400 + k * 16 + i));
    ready_in = 1'b1;
    release_init();
    drain("t4_drain", 100);
    check("t4_lane1_pops", 32'(pop_cnt[1]), 0);
    check("t4_lane1_left", 32'(fq[1].size()), 3);
    check("t4_dels", 32'(del_cyc.size()), 9);

    // All weights zero: nothing moves, idle
    start_test(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) load(k, DW'(12'h500 + k));
    release_init();
    tick(10);
    check("t5_pops", 32'(pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3]), 0);
    check("t5_idle", 32'(idle_out), 1);

    // Randomized weights, contents and backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      start_test(int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(15)), int'($urandom_range(15)));
      for (int k = 0; k < 4; k++) begin
        int n = int'($urandom_range(8));
        for (int i = 0; i < n; i++) load(k, DW'($urandom));
      end
      release_init();
      drain("rand_drain", 2000);
    end
    rand_ready = 1'b0;

    // Reset in the middle of a stalled transfer
    start_test(1, 1, 1, 1);
    for (int i = 0; i < 6; i++) load(0, DW'(12'h600 + i));
    ready_in = 1'b0;
    release_init();
    tick(5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(valid_out), 0);
    check("mid_rst_data", 32'(data_out), 0);
    check("mid_rst_pop", 32'(pop_bp), 0);
    check("mid_rst_idle", 32'(idle_out), 1);
    npops = pop_cnt[0];
    tick(2);
    check("mid_rst_no_pop", 32'(pop_cnt[0]), 32'(npops));
    reset = 1'b0;
    tick(3);
    check("after_rst_valid", 32'(valid_out), 0);
    check("after_rst_idle", 32'(idle_out), 1);

`ifdef QOS_MERGER_STATS_EN
    start_test(1, 1, 1, 1);
    for (int i = 0; i < 300; i++) load(3, DW'(i));
    ready_in = 1'b1;
    release_init();
    drain("stat_drain", 1000);
    stat_idx = 2'd3;
    #1;
    check("stat_sat", 32'(stat_count), 255);
    stat_idx = 2'd0;
    #1;
    check("stat_lane0", 32'(stat_count), 0);
    stat_idx = 2'd3;
    init     = 1'b1;
    tick(1);
    init = 1'b0;
    #1;
    check("stat_clear", 32'(stat_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
